// File: rtl/sd_sector_responder.sv
// Device-side responder for the hps_io sector handshake. Each sector request is served
// by streaming 256 words between the core's sector buffer and a word-addressed store.
module sd_sector_responder #(
    parameter int unsigned LBA_BITS = 15,
    parameter int unsigned WORDS    = 256
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [31:0]           sd_lba,
    input  logic                  sd_rd,
    input  logic                  sd_wr,
    output logic                  sd_ack,
    output logic [7:0]            sd_buff_addr,
    output logic [15:0]           sd_buff_dout,
    input  logic [15:0]           sd_buff_din,
    output logic                  sd_buff_wr,
    output logic [LBA_BITS+7:0]   mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy
);

    localparam int unsigned IDX_W  = 8;
    localparam int unsigned DATA_W = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_PUT,
        S_WR_ADDR,
        S_WR_SAMPLE,
        S_WR_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [LBA_BITS-1:0]   lba_q, lba_d;
    logic [DATA_W-1:0]     dout_d;
    logic [DATA_W-1:0]     wdata_d;
    logic                  ack_d;
    logic                  buff_wr_d;
    logic                  mem_rd_d;
    logic                  mem_wr_d;
    logic                  busy_d;

    // Sector number bits above LBA_BITS are deliberately dropped (address wraps).
    if (LBA_BITS < 32) begin : g_lba_hi
        logic lba_hi_unused;
        assign lba_hi_unused = |sd_lba[31:LBA_BITS];
    end

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lba_d   = lba_q;
        dout_d  = sd_buff_dout;
        wdata_d = mem_wdata;

        case (state_q)
            S_IDLE: begin
                if (sd_rd | sd_wr) begin
                    lba_d   = sd_lba[LBA_BITS-1:0];
                    idx_d   = '0;
                    state_d = sd_rd ? S_RD_REQ : S_WR_ADDR;
                end
            end
            S_RD_REQ: begin
                if (mem_ready) begin
                    dout_d  = mem_rdata;
                    state_d = S_RD_PUT;
                end
            end
            S_RD_PUT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_RD_REQ;
                end
            end
            S_WR_ADDR: begin
                state_d = S_WR_SAMPLE;
            end
            S_WR_SAMPLE: begin
                // Buffer read data arrives one cycle after the address was presented.
                wdata_d = sd_buff_din;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (mem_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_WR_ADDR;
                    end
                end
            end
            S_DONE: begin
                // Hold off until the initiator has withdrawn both requests.
                if (!sd_rd && !sd_wr) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ack_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        buff_wr_d = (state_d == S_RD_PUT);
        mem_rd_d  = (state_d == S_RD_REQ);
        mem_wr_d  = (state_d == S_WR_WAIT);
        busy_d    = (state_d != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            lba_q        <= '0;
            sd_buff_dout <= '0;
            mem_wdata    <= '0;
            sd_ack       <= 1'b0;
            sd_buff_wr   <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            lba_q        <= lba_d;
            sd_buff_dout <= dout_d;
            mem_wdata    <= wdata_d;
            sd_ack       <= ack_d;
            sd_buff_wr   <= buff_wr_d;
            mem_rd       <= mem_rd_d;
            mem_wr       <= mem_wr_d;
            busy         <= busy_d;
        end
    end

    assign sd_buff_addr = idx_q;
    assign mem_addr     = {lba_q, idx_q};

endmodule
